id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
ID/EX pipeline stage for the RV32I pipeline. It registers the decoder's control bundle, register indices and PC into the EX stage, and detects load-use hazards against the instruction currently in EX. It inserts bubbles on hazard or branch/jump flush, latches the terminate (halt) condition, and keeps a saturating count of inserted bubbles.

Parameters:
XLEN, 32, datapath/PC width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  ID holds a real instruction
id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i, id_regwrite_i, id_terminate_i, id_asource_i, id_jump_i  in  1 each  decoded control bits
id_aluop_i  in  3  decoded ALU op class
id_read_part_i  in  3  load width/sign select
id_write_part_i  in  2  store width select
id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
id_uses_rs2_i  in  1  instruction reads rs2 (R-type, store, branch)
id_pc_i  in  XLEN  PC of ID instruction
flush_i  in  1  branch/jump taken in EX; kill ID instruction
hold_i  in  1  downstream freeze; EX register keeps contents
ex_* outputs  out  same widths as id_* inputs  registered control, indices, PC
ex_valid_o  out  1  EX holds a real instruction
stall_o  out  1  freeze PC and IF/ID register this cycle
halted_o  out  1  terminate has reached EX; sticky
bubble_cnt_o  out  CNT_W  bubbles inserted, saturating

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, ex_valid_o=0, halted_o=0, bubble_cnt_o=0. stall_o is combinational and evaluates to 0 while in reset. Deassertion is sampled synchronously on the next rising edge.
- Load-use hazard (combinational, from registered EX fields): lu = ex_valid_o & ex_memread_o & (ex_rd_o!=0) & id_valid_i & ((ex_rd_o==id_rs1_i) | (id_uses_rs2_i & ex_rd_o==id_rs2_i)).
- stall_o = halted_o | hold_i | (lu & ~flush_i).
- Per-edge update priority, highest first:
  1. halted_o=1: load a bubble every cycle. Inputs are ignored and the counter is frozen.
  2. hold_i=1: all ex_* hold their values. flush_i is ignored this cycle, and the upstream source must keep it asserted until hold_i drops.
  3. flush_i=1: load a bubble, counter +1.
  4. lu=1: load a bubble, counter +1. The ID instruction is replayed next cycle because stall_o held IF/ID.
  5. Otherwise: capture all id_* fields. ex_valid_o=id_valid_i.
- Bubble: every control bit, ex_aluop_o, read_part and write_part are 0, and ex_valid_o=0. ex_rd_o, rs1 and rs2 are 0. ex_pc_o keeps its previous value.
- Halt: when an edge captures id_terminate_i=1 with id_valid_i=1, ex_terminate_o=1 for that one EX cycle. halted_o sets on the following edge and stays set until reset. A flushed or bubbled terminate never halts.
- Latency: one cycle from ID capture to the ex_* outputs. A load-use hazard costs exactly one bubble.
- Counter: increments by 1 per inserted bubble. It saturates at all-ones and does not wrap. Reset clears it.
- Flush and lu in the same cycle: a single bubble is inserted, the counter increments by 1, and stall_o=0 so IF fetches the target.
- rd=x0 load never causes a hazard.
- Reset asserted mid-stall clears everything immediately. No partial state survives.

Decomposition:
- Shared package rv32_pipe_pkg:
  - ctrl_t struct with the 15 control fields.
  - ALUOp encoding constants: ADD=3'b000, BR=3'b001, R=3'b010, I=3'b011, LUI=3'b100.
  - BUBBLE_CTRL constant (all zero).
- One natural sub-module: hazard_detect (purely combinational lu/stall_o logic), instantiated once. The register, halt latch and counter stay in the top.

Test Plan:
- Normal capture: reset release, feed ADDI x5 (regwrite=1, alusrc=1, aluop=011, pc=0x10) -> next edge ex_regwrite_o=1, ex_aluop_o=3'b011, ex_rd_o=5, ex_pc_o=0x10, stall_o=0.
- Load-use: LW x6 captured, then ADD x7,x6,x1 in ID -> stall_o=1 one cycle, then one bubble in EX (ex_valid_o=0), ADD captured next edge, bubble_cnt_o=1.
- No false hazard: LW x0 followed by ADD using x0, or LW x6 followed by ADDI with rs2 field=6 and id_uses_rs2_i=0 -> stall_o=0, no bubble.
- Flush+hazard together: lu=1 and flush_i=1 same cycle -> stall_o=0, one bubble, bubble_cnt_o +1 only.
- Hold: hold_i=1 for 3 cycles with changing ID inputs -> ex_* constant, stall_o=1, counter unchanged.
- Halt and reset: ECALL-type terminate captured -> ex_terminate_o=1 one cycle, then halted_o=1, stall_o=1, EX bubbles forever. Pulse rst_n low mid-halt -> all outputs 0 asynchronously. Force 0xFFFF bubbles -> bubble_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared control bundle and ALU op encodings for the RV32I pipeline
package rv32_pipe_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_BR  = 3'b001,
        ALU_R   = 3'b010,
        ALU_I   = 3'b011,
        ALU_LUI = 3'b100
    } aluop_e;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       terminate;
        logic       asource;
        logic       jump;
        logic [2:0] aluop;
        logic [2:0] read_part;
        logic [1:0] write_part;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_ctrl_stage_hazard_detect.sv
// hazard_detect: load-use detection and front-end stall request
module hazard_detect (
    input  logic       rst_n,
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs2_i,
    input  logic       flush_i,
    input  logic       hold_i,
    input  logic       halted_i,
    output logic       lu_o,
    output logic       stall_o
);
    assign lu_o = ex_valid_i & ex_memread_i & (ex_rd_i != 5'd0) & id_valid_i &
                  ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));
    // a taken flush replaces the stall so IF can fetch the target
    assign stall_o = rst_n & (halted_i | hold_i | (lu_o & ~flush_i));
endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: ID/EX control register with load-use bubbles, halt latch and bubble counter
module id_ex_ctrl_stage
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic             id_branch_i,
    input  logic             id_memread_i,
    input  logic             id_memtoreg_i,
    input  logic             id_memwrite_i,
    input  logic             id_alusrc_i,
    input  logic             id_regwrite_i,
    input  logic             id_terminate_i,
    input  logic             id_asource_i,
    input  logic             id_jump_i,
    input  logic [2:0]       id_aluop_i,
    input  logic [2:0]       id_read_part_i,
    input  logic [1:0]       id_write_part_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_uses_rs2_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             ex_branch_o,
    output logic             ex_memread_o,
    output logic             ex_memtoreg_o,
    output logic             ex_memwrite_o,
    output logic             ex_alusrc_o,
    output logic             ex_regwrite_o,
    output logic             ex_terminate_o,
    output logic             ex_asource_o,
    output logic             ex_jump_o,
    output logic [2:0]       ex_aluop_o,
    output logic [2:0]       ex_read_part_o,
    output logic [1:0]       ex_write_part_o,
    output logic [4:0]       ex_rs1_o,
    output logic [4:0]       ex_rs2_o,
    output logic [4:0]       ex_rd_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic             ex_valid_o,
    output logic             stall_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    ctrl_t id_ctrl, ex_ctrl;
    logic  lu;

    assign id_ctrl = '{branch: id_branch_i, memread: id_memread_i, memtoreg: id_memtoreg_i,
                       memwrite: id_memwrite_i, alusrc: id_alusrc_i, regwrite: id_regwrite_i,
                       terminate: id_terminate_i, asource: id_asource_i, jump: id_jump_i,
                       aluop: id_aluop_i, read_part: id_read_part_i, write_part: id_write_part_i,
                       rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i};

    assign ex_branch_o     = ex_ctrl.branch;
    assign ex_memread_o    = ex_ctrl.memread;
    assign ex_memtoreg_o   = ex_ctrl.memtoreg;
    assign ex_memwrite_o   = ex_ctrl.memwrite;
    assign ex_alusrc_o     = ex_ctrl.alusrc;
    assign ex_regwrite_o   = ex_ctrl.regwrite;
    assign ex_terminate_o  = ex_ctrl.terminate;
    assign ex_asource_o    = ex_ctrl.asource;
    assign ex_jump_o       = ex_ctrl.jump;
    assign ex_aluop_o      = ex_ctrl.aluop;
    assign ex_read_part_o  = ex_ctrl.read_part;
    assign ex_write_part_o = ex_ctrl.write_part;
    assign ex_rs1_o        = ex_ctrl.rs1;
    assign ex_rs2_o        = ex_ctrl.rs2;
    assign ex_rd_o         = ex_ctrl.rd;

    hazard_detect u_hazard (
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid_o),
        .ex_memread_i (ex_ctrl.memread),
        .ex_rd_i      (ex_ctrl.rd),
        .id_valid_i   (id_valid_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_uses_rs2_i(id_uses_rs2_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .halted_i     (halted_o),
        .lu_o         (lu),
        .stall_o      (stall_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl      <= BUBBLE_CTRL;
            ex_pc_o      <= '0;
            ex_valid_o   <= 1'b0;
            halted_o     <= 1'b0;
            bubble_cnt_o <= '0;
        end else if (halted_o) begin
            ex_ctrl    <= BUBBLE_CTRL;
            ex_valid_o <= 1'b0;
        end else begin
            // a bubble carries terminate=0, so only a real captured terminate halts
            halted_o <= ex_ctrl.terminate & ex_valid_o;
            if (!hold_i) begin
                if (flush_i | lu) begin
                    ex_ctrl    <= BUBBLE_CTRL;
                    ex_valid_o <= 1'b0;
                    if (!(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
                end else begin
                    ex_ctrl    <= id_ctrl;
                    ex_pc_o    <= id_pc_i;
                    ex_valid_o <= id_valid_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage: vector table plus scoreboard and hand sequences for id_ex_ctrl_stage
module tb_id_ex_ctrl_stage;
    import rv32_pipe_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i;
    logic        id_alusrc_i, id_regwrite_i, id_terminate_i, id_asource_i, id_jump_i;
    logic [2:0]  id_aluop_i, id_read_part_i;
    logic [1:0]  id_write_part_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_uses_rs2_i, flush_i, hold_i;
    logic [31:0] id_pc_i;
    logic        ex_branch_o, ex_memread_o, ex_memtoreg_o, ex_memwrite_o, ex_alusrc_o;
    logic        ex_regwrite_o, ex_terminate_o, ex_asource_o, ex_jump_o;
    logic [2:0]  ex_aluop_o, ex_read_part_o;
    logic [1:0]  ex_write_part_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [31:0] ex_pc_o;
    logic        ex_valid_o, stall_o, halted_o;
    logic [15:0] bubble_cnt_o;

    id_ex_ctrl_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_branch_i(id_branch_i), .id_memread_i(id_memread_i),
        .id_memtoreg_i(id_memtoreg_i), .id_memwrite_i(id_memwrite_i), .id_alusrc_i(id_alusrc_i),
        .id_regwrite_i(id_regwrite_i), .id_terminate_i(id_terminate_i), .id_asource_i(id_asource_i),
        .id_jump_i(id_jump_i), .id_aluop_i(id_aluop_i), .id_read_part_i(id_read_part_i),
        .id_write_part_i(id_write_part_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_uses_rs2_i(id_uses_rs2_i), .id_pc_i(id_pc_i), .flush_i(flush_i), .hold_i(hold_i),
        .ex_branch_o(ex_branch_o), .ex_memread_o(ex_memread_o), .ex_memtoreg_o(ex_memtoreg_o),
        .ex_memwrite_o(ex_memwrite_o), .ex_alusrc_o(ex_alusrc_o), .ex_regwrite_o(ex_regwrite_o),
        .ex_terminate_o(ex_terminate_o), .ex_asource_o(ex_asource_o), .ex_jump_o(ex_jump_o),
        .ex_aluop_o(ex_aluop_o), .ex_read_part_o(ex_read_part_o), .ex_write_part_o(ex_write_part_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_pc_o(ex_pc_o),
        .ex_valid_o(ex_valid_o), .stall_o(stall_o), .halted_o(halted_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, memread, regwrite, uses2, flush, hold;
        logic [2:0]  aluop;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic        e_stall, e_valid, e_memread, e_regwrite;
        logic [2:0]  e_aluop;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic        valid, memread, regwrite;
        logic [2:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [15:0] cnt;
    } exp_t;

    int   checks = 0, errors = 0;
    vec_t tv[20];
    exp_t sb[$];
    exp_t e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic v, mr, rw, u2, fl, ho, input logic [2:0] op,
                                 input logic [4:0] r1, r2, rd, input logic [31:0] pc,
                                 input logic es, ev, emr, erw, input logic [2:0] eop,
                                 input logic [4:0] erd, input logic [31:0] epc, input logic [15:0] ec);
        vec_t t;
        t.valid = v; t.memread = mr; t.regwrite = rw; t.uses2 = u2; t.flush = fl; t.hold = ho;
        t.aluop = op; t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.pc = pc;
        t.e_stall = es; t.e_valid = ev; t.e_memread = emr; t.e_regwrite = erw;
        t.e_aluop = eop; t.e_rd = erd; t.e_pc = epc; t.e_cnt = ec;
        return t;
    endfunction

    task automatic idle();
        {id_valid_i, id_branch_i, id_memread_i, id_memtoreg_i, id_memwrite_i} = '0;
        {id_alusrc_i, id_regwrite_i, id_terminate_i, id_asource_i, id_jump_i} = '0;
        id_aluop_i = '0; id_read_part_i = '0; id_write_part_i = '0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_uses_rs2_i = 1'b0;
        id_pc_i = '0; flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        idle();
        id_valid_i = v.valid; id_memread_i = v.memread; id_memtoreg_i = v.memread;
        id_regwrite_i = v.regwrite; id_uses_rs2_i = v.uses2; flush_i = v.flush; hold_i = v.hold;
        id_aluop_i = v.aluop; id_alusrc_i = (v.aluop == ALU_I);
        id_rs1_i = v.rs1; id_rs2_i = v.rs2; id_rd_i = v.rd; id_pc_i = v.pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             v  mr rw u2 fl ho op  rs1 rs2 rd  pc     | st ev emr erw eop erd epc    cnt
        tv[0]  = mkv(1, 0, 1, 0, 0, 0, 3,  1,  0,  5, 'h10,    0, 1, 0, 1, 3,  5, 'h10, 0);
        tv[1]  = mkv(1, 1, 1, 0, 0, 0, 0,  2,  0,  6, 'h14,    0, 1, 1, 1, 0,  6, 'h14, 0);
        tv[2]  = mkv(1, 0, 1, 1, 0, 0, 2,  6,  1,  7, 'h18,    1, 0, 0, 0, 0,  0, 'h14, 1);
        tv[3]  = mkv(1, 0, 1, 1, 0, 0, 2,  6,  1,  7, 'h18,    0, 1, 0, 1, 2,  7, 'h18, 1);
        tv[4]  = mkv(1, 1, 1, 0, 0, 0, 0,  3,  0,  0, 'h1c,    0, 1, 1, 1, 0,  0, 'h1c, 1);
        tv[5]  = mkv(1, 0, 1, 1, 0, 0, 2,  0,  0,  8, 'h20,    0, 1, 0, 1, 2,  8, 'h20, 1);
        tv[6]  = mkv(1, 1, 1, 0, 0, 0, 0,  1,  0,  6, 'h24,    0, 1, 1, 1, 0,  6, 'h24, 1);
        tv[7]  = mkv(1, 0, 1, 0, 0, 0, 3,  2,  6,  9, 'h28,    0, 1, 0, 1, 3,  9, 'h28, 1);
        tv[8]  = mkv(1, 1, 1, 0, 0, 0, 0,  1,  0,  6, 'h2c,    0, 1, 1, 1, 0,  6, 'h2c, 1);
        tv[9]  = mkv(1, 0, 1, 1, 1, 0, 2,  6,  1, 10, 'h30,    0, 0, 0, 0, 0,  0, 'h2c, 2);
        tv[10] = mkv(1, 1, 1, 0, 0, 0, 0,  0,  0, 11, 'h34,    0, 1, 1, 1, 0, 11, 'h34, 2);
        tv[11] = mkv(1, 0, 0, 1, 0, 0, 0,  1, 11,  0, 'h38,    1, 0, 0, 0, 0,  0, 'h34, 3);
        tv[12] = mkv(1, 0, 0, 1, 0, 0, 0,  1, 11,  0, 'h38,    0, 1, 0, 0, 0,  0, 'h38, 3);
        tv[13] = mkv(1, 0, 1, 0, 0, 1, 3,  1,  0, 12, 'h3c,    1, 1, 0, 0, 0,  0, 'h38, 3);
        tv[14] = mkv(1, 0, 1, 0, 1, 1, 3,  1,  0, 13, 'h40,    1, 1, 0, 0, 0,  0, 'h38, 3);
        tv[15] = mkv(1, 1, 1, 0, 0, 1, 0,  2,  0, 14, 'h44,    1, 1, 0, 0, 0,  0, 'h38, 3);
        tv[16] = mkv(1, 0, 1, 0, 0, 0, 3,  1,  0, 12, 'h3c,    0, 1, 0, 1, 3, 12, 'h3c, 3);
        tv[17] = mkv(0, 0, 1, 0, 0, 0, 3,  1,  0, 13, 'h40,    0, 0, 0, 1, 3, 13, 'h40, 3);
        tv[18] = mkv(0, 1, 1, 0, 0, 0, 0,  1,  0, 14, 'h44,    0, 0, 1, 1, 0, 14, 'h44, 3);
        tv[19] = mkv(1, 0, 1, 0, 0, 0, 2, 14,  0, 15, 'h48,    0, 1, 0, 1, 2, 15, 'h48, 3);

        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_valid", 32'(ex_valid_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        chk("rst_cnt", 32'(bubble_cnt_o), 0);
        chk("rst_pc", ex_pc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(tv[i]);
            #1;
            chk($sformatf("stall[%0d]", i), 32'(stall_o), 32'(tv[i].e_stall));
            sb.push_back('{valid: tv[i].e_valid, memread: tv[i].e_memread, regwrite: tv[i].e_regwrite,
                           aluop: tv[i].e_aluop, rd: tv[i].e_rd, pc: tv[i].e_pc, cnt: tv[i].e_cnt});
            tick();
            e = sb.pop_front();
            chk($sformatf("valid[%0d]", i), 32'(ex_valid_o), 32'(e.valid));
            chk($sformatf("memread[%0d]", i), 32'(ex_memread_o), 32'(e.memread));
            chk($sformatf("regwrite[%0d]", i), 32'(ex_regwrite_o), 32'(e.regwrite));
            chk($sformatf("aluop[%0d]", i), 32'(ex_aluop_o), 32'(e.aluop));
            chk($sformatf("rd[%0d]", i), 32'(ex_rd_o), 32'(e.rd));
            chk($sformatf("pc[%0d]", i), ex_pc_o, e.pc);
            chk($sformatf("cnt[%0d]", i), 32'(bubble_cnt_o), 32'(e.cnt));
        end

        // every field captured, then flushed to a bubble that keeps the PC
        idle();
        {id_valid_i, id_branch_i, id_memtoreg_i, id_memwrite_i, id_alusrc_i} = '1;
        {id_regwrite_i, id_asource_i, id_jump_i} = '1;
        id_aluop_i = ALU_LUI; id_read_part_i = 3'b101; id_write_part_i = 2'b10;
        id_rs1_i = 21; id_rs2_i = 22; id_rd_i = 23; id_pc_i = 32'hDEADBEE0;
        tick();
        chk("cap_branch", 32'(ex_branch_o), 1);
        chk("cap_memread", 32'(ex_memread_o), 0);
        chk("cap_memtoreg", 32'(ex_memtoreg_o), 1);
        chk("cap_memwrite", 32'(ex_memwrite_o), 1);
        chk("cap_alusrc", 32'(ex_alusrc_o), 1);
        chk("cap_asource", 32'(ex_asource_o), 1);
        chk("cap_jump", 32'(ex_jump_o), 1);
        chk("cap_terminate", 32'(ex_terminate_o), 0);
        chk("cap_aluop", 32'(ex_aluop_o), 4);
        chk("cap_read_part", 32'(ex_read_part_o), 5);
        chk("cap_write_part", 32'(ex_write_part_o), 2);
        chk("cap_rs1", 32'(ex_rs1_o), 21);
        chk("cap_rs2", 32'(ex_rs2_o), 22);
        chk("cap_pc", ex_pc_o, 32'hDEADBEE0);
        flush_i = 1'b1;
        tick();
        chk("bub_ctrl", {29'd0, ex_branch_o, ex_jump_o, ex_memwrite_o}, 0);
        chk("bub_fields", {18'd0, ex_aluop_o, ex_read_part_o, ex_write_part_o, ex_rs1_o}, 0);
        chk("bub_regs", {22'd0, ex_rs2_o, ex_rd_o}, 0);
        chk("bub_valid", 32'(ex_valid_o), 0);
        chk("bub_pc", ex_pc_o, 32'hDEADBEE0);
        chk("bub_cnt", 32'(bubble_cnt_o), 4);

        // a flushed terminate must never halt
        idle();
        id_valid_i = 1'b1; id_terminate_i = 1'b1; flush_i = 1'b1;
        tick();
        chk("fterm_ex", 32'(ex_terminate_o), 0);
        chk("fterm_cnt", 32'(bubble_cnt_o), 5);
        idle();
        tick();
        tick();
        chk("fterm_halt", 32'(halted_o), 0);

        // real terminate: one EX cycle of terminate, then sticky halt
        id_valid_i = 1'b1; id_terminate_i = 1'b1; id_pc_i = 32'h100;
        tick();
        idle();
        id_valid_i = 1'b1; id_regwrite_i = 1'b1; id_rd_i = 5; id_pc_i = 32'h104;
        #1;
        chk("term_ex", 32'(ex_terminate_o), 1);
        chk("term_halt0", 32'(halted_o), 0);
        chk("term_stall0", 32'(stall_o), 0);
        tick();
        chk("halt_set", 32'(halted_o), 1);
        chk("halt_stall", 32'(stall_o), 1);
        chk("halt_term1", 32'(ex_terminate_o), 0);
        chk("halt_rd", 32'(ex_rd_o), 5);
        tick();
        chk("halt_bub_valid", 32'(ex_valid_o), 0);
        chk("halt_bub_rd", 32'(ex_rd_o), 0);
        flush_i = 1'b1;
        repeat (3) tick();
        chk("halt_cnt_frozen", 32'(bubble_cnt_o), 5);
        chk("halt_sticky", 32'(halted_o), 1);
        chk("halt_valid", 32'(ex_valid_o), 0);

        // asynchronous reset in the middle of a halt, with hold asserted
        hold_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_halted", 32'(halted_o), 0);
        chk("areset_stall", 32'(stall_o), 0);
        chk("areset_cnt", 32'(bubble_cnt_o), 0);
        chk("areset_pc", ex_pc_o, 0);
        chk("areset_regwrite", 32'(ex_regwrite_o), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();

        // reset while a load-use stall is pending
        id_valid_i = 1'b1; id_memread_i = 1'b1; id_regwrite_i = 1'b1; id_rd_i = 6;
        tick();
        idle();
        id_valid_i = 1'b1; id_rs1_i = 6; id_rd_i = 7;
        #1;
        chk("mid_stall", 32'(stall_o), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_stall_rst", 32'(stall_o), 0);
        chk("mid_memread_rst", 32'(ex_memread_o), 0);
        chk("mid_rd_rst", 32'(ex_rd_o), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        tick();

        // counter saturation
        flush_i = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(bubble_cnt_o), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(bubble_cnt_o), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(bubble_cnt_o), 32'hFFFF);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
